// File: rtl/tx_relatorio_cargo_pkg.sv
// Shared definitions for the cargo-elevator report transmitter: byte markers,
// FSM encodings shown on db_estado, and byte assembly helpers.
package tx_relatorio_cargo_pkg;

    localparam int CLKS_PER_BIT_PADRAO = 434;

    localparam logic [1:0] MARCA_HEADER = 2'b11;
    localparam logic [1:0] MARCA_ITEM   = 2'b01;

    localparam logic [3:0] INICIAL     = 4'd0;
    localparam logic [3:0] CONTA_END   = 4'd1;
    localparam logic [3:0] CONTA_LE    = 4'd2;
    localparam logic [3:0] HEADER      = 4'd3;
    localparam logic [3:0] ESPERA_HDR  = 4'd4;
    localparam logic [3:0] BUSCA       = 4'd5;
    localparam logic [3:0] VERIFICA    = 4'd6;
    localparam logic [3:0] ENVIA       = 4'd7;
    localparam logic [3:0] ESPERA_ITEM = 4'd8;
    localparam logic [3:0] FIM         = 4'd9;

    function automatic logic [7:0] monta_header(input logic [1:0] andar, input logic [3:0] n_itens);
        return {MARCA_HEADER, andar, n_itens};
    endfunction

    function automatic logic [7:0] monta_item(input logic [1:0] tipo, input logic [1:0] destino);
        return {MARCA_ITEM, tipo, destino, 2'b00};
    endfunction

endpackage

// File: rtl/tx_relatorio_cargo_if.sv
// Control, contents-RAM and serial-line signals of the report transmitter.
interface tx_relatorio_cargo_if #(
    parameter int ADDR_W = 4
);
    logic              enviar;
    logic [1:0]        andar_atual;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_valido;
    logic [1:0]        ram_tipo;
    logic [1:0]        ram_destino;
    logic              TX;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;

    // master: the reporter itself; slave: control unit, contents RAM and line
    modport master (
        input  enviar, andar_atual, ram_valido, ram_tipo, ram_destino,
        output ram_addr, TX, ocupado, pronto, db_estado
    );
    modport slave (
        output enviar, andar_atual, ram_valido, ram_tipo, ram_destino,
        input  ram_addr, TX, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/tx_serial_8N1.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit, each
// held CLKS_PER_BIT cycles; pronto pulses for one cycle after the stop bit.
module tx_serial_8N1
    import tx_relatorio_cargo_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       TX,
    output logic       pronto
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] ULTIMO_CLK = CW'(CLKS_PER_BIT - 1);

    logic          ativo;
    logic [CW-1:0] baud;
    logic [3:0]    bit_idx;
    logic [8:0]    quadro;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ativo   <= 1'b0;
            baud    <= '0;
            bit_idx <= 4'd0;
            quadro  <= '1;
            TX      <= 1'b1;
            pronto  <= 1'b0;
        end else begin
            // NOTE: pronto defaults low every cycle, so it can only ever be a one-cycle pulse.
            pronto <= 1'b0;
            if (!ativo) begin
                if (partida) begin
                    ativo   <= 1'b1;
                    baud    <= '0;
                    bit_idx <= 4'd0;
                    quadro  <= {1'b1, dados};
                    TX      <= 1'b0;
                end
            end else if (baud != ULTIMO_CLK) begin
                baud <= baud + 1'b1;
            end else begin
                baud <= '0;
                if (bit_idx == 4'd9) begin
                    ativo  <= 1'b0;
                    pronto <= 1'b1;
                end else begin
                    // quadro[0] is the next bit to drive; stop bit shifts in from the top
                    bit_idx <= bit_idx + 4'd1;
                    TX      <= quadro[0];
                    quadro  <= {1'b1, quadro[8:1]};
                end
            end
        end
    end

endmodule

// File: rtl/tx_relatorio_cargo.sv
// Cargo report transmitter: counts valid RAM entries, then sends a header byte
// and one byte per valid entry over an 8N1 line.
module tx_relatorio_cargo
    import tx_relatorio_cargo_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 4
) (
    input logic                  clock,
    input logic                  reset,
    tx_relatorio_cargo_if.master bus
);
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);

    logic [3:0]        estado;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        n_itens;
    logic [3:0]        enviados;
    logic [1:0]        andar;
    logic [7:0]        item;
    logic              linha_ocupada;
    logic              pronto_r;
    logic              linha_livre;
    logic              ser_partida;
    logic              ser_pronto;
    logic [7:0]        ser_dados;

    // The line can take a new byte once the previous one has finished its stop bit
    assign linha_livre = !linha_ocupada || ser_pronto;
    assign ser_partida = (estado == HEADER) || (estado == ENVIA && linha_livre);
    assign ser_dados   = (estado == HEADER) ? monta_header(andar, n_itens) : item;

    assign bus.ram_addr  = addr;
    assign bus.ocupado   = (estado != INICIAL);
    assign bus.pronto    = pronto_r;
    assign bus.db_estado = estado;

    tx_serial_8N1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serial (
        .clock  (clock),
        .reset  (reset),
        .partida(ser_partida),
        .dados  (ser_dados),
        .TX     (bus.TX),
        .pronto (ser_pronto)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado        <= INICIAL;
            addr          <= '0;
            n_itens       <= 4'd0;
            enviados      <= 4'd0;
            andar         <= 2'd0;
            item          <= 8'd0;
            linha_ocupada <= 1'b0;
            pronto_r      <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            if (ser_partida) begin
                linha_ocupada <= 1'b1;
            end else if (ser_pronto) begin
                linha_ocupada <= 1'b0;
            end

            case (estado)
                INICIAL: begin
                    // a request coinciding with pronto belongs to the finished packet
                    if (bus.enviar && !pronto_r) begin
                        andar    <= bus.andar_atual;
                        n_itens  <= 4'd0;
                        enviados <= 4'd0;
                        addr     <= '0;
                        estado   <= CONTA_END;
                    end
                end
                CONTA_END: estado <= CONTA_LE;
                CONTA_LE: begin
                    if (bus.ram_valido && n_itens != 4'hF) begin
                        n_itens <= n_itens + 4'd1;
                    end
                    if (addr == ULTIMO) begin
                        addr   <= '0;
                        estado <= HEADER;
                    end else begin
                        addr   <= addr + 1'b1;
                        estado <= CONTA_END;
                    end
                end
                HEADER:     estado <= ESPERA_HDR;
                ESPERA_HDR: estado <= (n_itens == 4'd0) ? FIM : BUSCA;
                BUSCA:      estado <= VERIFICA;
                VERIFICA: begin
                    // latch the byte so ENVIA can wait for the line independently of the RAM
                    if (bus.ram_valido && enviados < n_itens) begin
                        item   <= monta_item(bus.ram_tipo, bus.ram_destino);
                        estado <= ENVIA;
                    end else if (addr != ULTIMO) begin
                        addr   <= addr + 1'b1;
                        estado <= BUSCA;
                    end else begin
                        addr   <= '0;
                        estado <= FIM;
                    end
                end
                ENVIA: begin
                    if (linha_livre) begin
                        enviados <= enviados + 4'd1;
                        estado   <= ESPERA_ITEM;
                    end
                end
                ESPERA_ITEM: begin
                    if (addr != ULTIMO) begin
                        addr   <= addr + 1'b1;
                        estado <= BUSCA;
                    end else begin
                        addr   <= '0;
                        estado <= FIM;
                    end
                end
                FIM: begin
                    if (linha_livre) begin
                        pronto_r <= 1'b1;
                        estado   <= INICIAL;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

endmodule
